// File: rtl/multiplication_seq.sv
// Sequential unsigned shift-and-add multiplier: WIDTH x WIDTH -> 2*WIDTH product.
// Latency: done pulses WIDTH cycles after the accepting edge; one op per WIDTH+2 cycles.
// Backpressure: ready=0 from acceptance until after done; start is ignored while busy.
module multiplication_seq #(
  parameter int WIDTH = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               ready,
  output logic               done,
  output logic [2*WIDTH-1:0] Res,
  output logic               overflow
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [PW-1:0]   r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]   r_acc;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_res;
  logic            r_ovf;
  logic            r_ready;
  logic            r_done;

  logic [PW-1:0]   w_acc_sum;
  logic            w_last;
  logic            w_accept;

  // Accumulator value after the current iteration; also the final product on the last one.
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : {PW{1'b0}});
  // The iteration being performed this cycle is the WIDTH-th one.
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_accept  = (r_state == S_IDLE) && start;

  // Next-state logic: fixed-length RUN, single-cycle DONE, no early exit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN:  if (w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Operand shift registers, accumulator and iteration counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (r_state == S_RUN) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  // Result and overflow change only when the last iteration completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_res <= '0;
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_res <= w_acc_sum;
      r_ovf <= |w_acc_sum[PW-1:WIDTH];
    end
  end

  // Registered handshake outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_nxt == S_IDLE);
      r_done  <= (w_state_nxt == S_DONE);
    end
  end

  assign ready    = r_ready;
  assign done     = r_done;
  assign Res      = r_res;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_multiplication_seq.sv
// Bench for multiplication_seq: vector table, random products vs. plain A*B,
// busy protection, mid-operation reset and back-to-back throughput.
module tb_multiplication_seq;

  localparam int W  = 10;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          ready;
  logic          done;
  logic [PW-1:0] Res;
  logic          overflow;

  int checks = 0;
  int errors = 0;

  multiplication_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .A(A), .B(B),
    .ready(ready), .done(done), .Res(Res), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [PW-1:0] res;
    logic          ovf;
  } vec_t;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Issue one multiply from IDLE and watch it to completion.
  // c counts negedges after the accepting edge t0; done is expected at c=W.
  task automatic mult(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb,
                      input logic [PW-1:0] prev, output logic [PW-1:0] res,
                      output logic ovf, output int lat, output int ndone);
    @(negedge clk);
    chk("ready_before_start", longint'(ready), 1);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    lat = -1; ndone = 0; res = '0; ovf = 1'b0;
    for (int c = 0; c < W + 6; c++) begin
      @(negedge clk);
      if (disturb && c <= W) begin
        start = (c % 2 == 0);
        A = (c % 2 == 0) ? W'(100) : W'($urandom);
        B = (c % 2 == 0) ? W'(100) : W'($urandom);
      end else begin
        start = 1'b0;
      end
      if (c == W - 1) chk("res_hold_during_run", longint'(Res), longint'(prev));
      if (c == W)     chk("ready_low_in_done", longint'(ready), 0);
      if (c == W + 1) chk("ready_after_done", longint'(ready), 1);
      if (done) begin
        ndone++;
        if (lat < 0) begin
          lat = c; res = Res; ovf = overflow;
        end
      end
    end
    start = 1'b0;
  endtask

  vec_t vecs[8];
  logic [PW-1:0] last_res;
  logic [PW-1:0] got_res;
  logic          got_ovf;
  int            lat;
  int            nd;

  initial begin
    vecs[0] = '{a: 10'd3,    b: 10'd5,    res: 20'd15,      ovf: 1'b0};
    vecs[1] = '{a: 10'd1023, b: 10'd1023, res: 20'd1046529, ovf: 1'b1};
    vecs[2] = '{a: 10'd0,    b: 10'd1023, res: 20'd0,       ovf: 1'b0};
    vecs[3] = '{a: 10'd1023, b: 10'd1,    res: 20'd1023,    ovf: 1'b0};
    vecs[4] = '{a: 10'd32,   b: 10'd32,   res: 20'd1024,    ovf: 1'b1};
    vecs[5] = '{a: 10'd31,   b: 10'd33,   res: 20'd1023,    ovf: 1'b0};
    vecs[6] = '{a: 10'd512,  b: 10'd2,    res: 20'd1024,    ovf: 1'b1};
    vecs[7] = '{a: 10'd1,    b: 10'd0,    res: 20'd0,       ovf: 1'b0};

    reset = 1'b1; start = 1'b0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", longint'(ready), 1);
    chk("reset_done", longint'(done), 0);
    chk("reset_res", longint'(Res), 0);
    chk("reset_ovf", longint'(overflow), 0);
    reset = 1'b0;
    last_res = '0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      mult(vecs[i].a, vecs[i].b, 1'b0, last_res, got_res, got_ovf, lat, nd);
      chk($sformatf("vec%0d_latency", i), lat, W);
      chk($sformatf("vec%0d_done_count", i), nd, 1);
      chk($sformatf("vec%0d_res", i), longint'(got_res), longint'(vecs[i].res));
      chk($sformatf("vec%0d_ovf", i), longint'(got_ovf), longint'(vecs[i].ovf));
      chk($sformatf("vec%0d_res_held", i), longint'(Res), longint'(vecs[i].res));
      last_res = vecs[i].res;
    end

    // Random operands against plain arithmetic.
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      longint prod;
      ra = (i % 5 == 0) ? W'(1023 - $urandom_range(0, 3)) : W'($urandom);
      rb = (i % 7 == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      prod = longint'(ra) * longint'(rb);
      mult(ra, rb, 1'b0, last_res, got_res, got_ovf, lat, nd);
      chk("rand_latency", lat, W);
      chk("rand_done_count", nd, 1);
      chk("rand_res", longint'(got_res), prod);
      chk("rand_ovf", longint'(got_ovf), (prod >= (longint'(1) << W)) ? 1 : 0);
      last_res = PW'(prod);
    end

    // Busy protection: start pulses and operand churn during RUN and DONE.
    mult(10'd7, 10'd9, 1'b1, last_res, got_res, got_ovf, lat, nd);
    chk("busy_latency", lat, W);
    chk("busy_done_count", nd, 1);
    chk("busy_res", longint'(got_res), 63);
    chk("busy_ovf", longint'(got_ovf), 0);
    last_res = 20'd63;

    // Reset four cycles after accepting 12*12.
    @(negedge clk);
    A = 10'd12; B = 10'd12; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_ready", longint'(ready), 1);
    chk("midreset_done", longint'(done), 0);
    chk("midreset_res", longint'(Res), 0);
    chk("midreset_ovf", longint'(overflow), 0);
    nd = 0;
    for (int c = 0; c < 2 * W; c++) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("midreset_no_done", nd, 0);
    chk("midreset_res_stays", longint'(Res), 0);

    // Back-to-back with start held high.
    begin
      int first, prev_t;
      first = -1; prev_t = -1; nd = 0;
      A = 10'd12; B = 10'd12; start = 1'b1;
      for (int c = 0; c < 4 * (W + 2) + 4; c++) begin
        @(negedge clk);
        if (done) begin
          nd++;
          chk("b2b_res", longint'(Res), 144);
          chk("b2b_ovf", longint'(overflow), 0);
          if (prev_t >= 0) chk("b2b_period", c - prev_t, W + 2);
          if (first < 0) first = c;
          prev_t = c;
        end else if (first >= 0) begin
          chk("b2b_res_hold", longint'(Res), 144);
        end else begin
          chk("b2b_res_before", longint'(Res), 0);
        end
      end
      start = 1'b0;
      chk("b2b_done_count", nd, 4);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiplication_seq.md
# multiplication_seq

Sequential unsigned shift-and-add multiplier for the calculator datapath. It is the inverse operator to the combinational restoring `division` block. It accepts two WIDTH-bit operands on a start/ready handshake and computes the full 2*WIDTH-bit product over WIDTH iterations, one multiplier bit per clock. It then presents the result with a one-cycle done strobe and an overflow flag for the WIDTH-bit calculator display path.

## Interface
- WIDTH, 10: operand width in bits; product is 2*WIDTH bits; must be >= 2.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- start  input  1  request to begin a multiply; accepted only when ready=1.
- A  input  WIDTH  multiplicand, unsigned; sampled on the accepting edge only.
- B  input  WIDTH  multiplier, unsigned; sampled on the accepting edge only.
- ready  output  1  high when idle and able to accept start.
- done  output  1  one-cycle pulse; Res/overflow valid from this cycle onward.
- Res  output  2*WIDTH  unsigned product A*B; held until the next done.
- overflow  output  1  high when Res[2*WIDTH-1:WIDTH] != 0, i.e. the product does not fit in WIDTH bits; held with Res.

## Operation
- FSM states: IDLE, RUN, DONE. The encoding is free.
- IDLE:
  - ready=1.
  - On an edge with start=1:
    - latch A into the multiplicand register (zero-extended to 2*WIDTH).
    - latch B into the multiplier shift register.
    - clear the accumulator and iteration counter.
    - go to RUN.
  - start=0 keeps the block in IDLE.
- RUN, one iteration per clock:
  - If multiplier[0]=1, accumulator += multiplicand.
  - Shift multiplicand left 1; shift multiplier right 1; counter += 1.
  - After exactly WIDTH iterations, go to DONE. There is no early exit on multiplier=0, so latency is fixed.
- Arithmetic:
  - The accumulator is 2*WIDTH bits and cannot overflow, since max (2^W-1)^2 < 2^(2W).
  - The counter is ceil(log2(WIDTH+1)) bits.
- On the RUN->DONE edge:
  - Res <= final accumulator.
  - overflow <= |accumulator[2W-1:W].
- DONE: lasts one cycle. done=1 and ready=0; the next state is IDLE unconditionally.
- start while RUN or DONE: ignored. Operands are not re-sampled, and the computation is not restarted or queued.
- A/B changing after acceptance: no effect on the result.
- Res and overflow change only on the RUN->DONE edge and on reset. They otherwise hold, including across subsequent IDLE cycles and during the next computation.

## Timing
- Reset (edge with reset=1, any state, including mid-RUN):
  - state=IDLE.
  - ready=1, done=0, Res=0, overflow=0.
  - accumulator, counter and operand registers cleared.
  - The in-flight result is discarded; no done is produced for it.
- reset has priority over start on the same edge.
- Accept edge t0 (ready=1, start=1): ready=0 from t0 to t0+WIDTH+1.
- RUN occupies the cycles after edges t0+1 .. t0+WIDTH-1 plus the cycle after t0; WIDTH RUN cycles in total.
- Edge t0+WIDTH: done=1, Res/overflow updated.
- Edge t0+WIDTH+1: done=0, ready=1.
- Fastest re-accept is at edge t0+WIDTH+2 (start held high continuously gives one multiply per WIDTH+2 cycles).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset values: hold reset 3 cycles from power-up -> ready=1, done=0, Res=0, overflow=0.
- Basic product (WIDTH=10): start with A=3, B=5 at edge t0 -> done=1 exactly in the cycle after edge t0+10; Res=15, overflow=0; ready=1 after edge t0+11; done high exactly one cycle.
- Max operands: A=1023, B=1023 -> Res=1046529, overflow=1.
- Boundary cases, each giving done at t0+10:
  - A=0, B=1023 -> Res=0, overflow=0.
  - A=1023, B=1 -> Res=1023, overflow=0.
  - A=32, B=32 -> Res=1024, overflow=1.
- Busy protection: accept A=7, B=9, then pulse start with A=100, B=100 during RUN and during DONE, and toggle A/B -> single done; Res=63; no second done.
- Reset mid-operation and back-to-back:
  - Reset 4 cycles after accepting 12*12 -> no done, Res=0, ready=1.
  - Then hold start high with A=12, B=12 -> Res=144 at each done, with done pulses exactly WIDTH+2=12 cycles apart; the previous Res holds between done pulses.
